// File: rtl/band_corr_framer_pkg.sv
// Shared encodings for the band correlation framer: word-select codes for the
// four words of a correlation tuple, and the writer/reader state encodings.
package band_corr_framer_pkg;

   localparam logic [1:0] W_R11   = 2'd0;
   localparam logic [1:0] W_R22   = 2'd1;
   localparam logic [1:0] W_R12RE = 2'd2;
   localparam logic [1:0] W_R12IM = 2'd3;

   typedef enum logic [1:0] {
      WR_HUNT = 2'd0,
      WR_FILL = 2'd1,
      WR_DROP = 2'd2
   } wr_state_e;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_e;

endpackage

// File: rtl/band_corr_framer_ram.sv
// Dual-bank simple dual-port tuple store: one tuple row per {bank, band},
// registered read data one cycle after the address.
module band_pingpong_ram
   import band_corr_framer_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [4*DW-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [4*DW-1:0] rdata
);

   logic [4*DW-1:0] mem_q [2**AW];
   logic [4*DW-1:0] rdata_q;

   // tuple write and registered read
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/band_corr_framer.sv
// Captures one frame of per-band correlation tuples into a ping-pong buffer and
// streams complete frames as ready/valid words; overflowing frames are dropped.
module band_corr_framer
   import band_corr_framer_pkg::*;
#(
   parameter int DIN_WIDTH       = 32,
   parameter int BANDS           = 4,
   parameter int FRAME_CNT_WIDTH = 16,
   parameter int OVF_CNT_WIDTH   = 8,
   localparam int BW             = $clog2(BANDS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DIN_WIDTH-1:0]       r11,
   input  logic [DIN_WIDTH-1:0]       r22,
   input  logic [DIN_WIDTH-1:0]       r12_re,
   input  logic [DIN_WIDTH-1:0]       r12_im,
   input  logic                       din_valid,
   input  logic [BW-1:0]              band_number,
   input  logic                       clear_flags,
   output logic [DIN_WIDTH-1:0]       dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [BW-1:0]              dout_band,
   output logic [1:0]                 dout_word,
   output logic                       dout_last,
   output logic [FRAME_CNT_WIDTH-1:0] dout_frame,
   output logic                       seq_err,
   output logic [OVF_CNT_WIDTH-1:0]   ovf_cnt
);

   localparam logic [BW-1:0]            ZERO_BAND = {BW{1'b0}};
   localparam logic [BW-1:0]            ONE_BAND  = BW'(1);
   localparam logic [BW-1:0]            LAST_BAND = BW'(BANDS - 1);
   localparam logic [OVF_CNT_WIDTH-1:0] OVF_ONE   = OVF_CNT_WIDTH'(1);
   localparam logic [OVF_CNT_WIDTH-1:0] OVF_MAX   = {OVF_CNT_WIDTH{1'b1}};

   wr_state_e                          wr_state_q, wr_state_d;
   logic                               wr_bank_q, wr_bank_d;
   logic [BW-1:0]                      exp_band_q, exp_band_d;
   logic [FRAME_CNT_WIDTH-1:0]         frame_cnt_q, frame_cnt_d;
   logic [1:0][FRAME_CNT_WIDTH-1:0]    tag_q, tag_d;
   logic [1:0]                         full_q, full_d;
   logic                               seq_err_q, seq_err_d;
   logic [OVF_CNT_WIDTH-1:0]           ovf_cnt_q, ovf_cnt_d;
   logic [1:0]                         set_s, rel_s;
   logic                               we_s;

   rd_state_e                          rd_state_q, rd_state_d;
   logic                               rd_bank_q, rd_bank_d;
   logic [BW-1:0]                      cur_band_q, cur_band_d;
   logic [1:0]                         cur_word_q, cur_word_d;
   logic [3:0][DIN_WIDTH-1:0]          row_q, row_d;
   logic [DIN_WIDTH-1:0]               dout_q, dout_d;
   logic                               dout_valid_q, dout_valid_d;
   logic                               dout_last_q, dout_last_d;
   logic [FRAME_CNT_WIDTH-1:0]         dout_frame_q, dout_frame_d;
   logic [BW:0]                        raddr_s;
   logic [3:0][DIN_WIDTH-1:0]          rdata_s;
   logic [3:0][DIN_WIDTH-1:0]          wdata_s;
   logic [1:0]                         nxt_word_s;
   logic [BW-1:0]                      nxt_band_s;

   assign wdata_s = {r12_im, r12_re, r22, r11};

   band_pingpong_ram #(
      .DW (DIN_WIDTH),
      .AW (BW + 1)
   ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr ({wr_bank_q, band_number}),
      .wdata (wdata_s),
      .raddr (raddr_s),
      .rdata (rdata_s)
   );

   // writer FSM, bank full flags and sticky error/overflow flags
   always_comb begin
      wr_state_d  = wr_state_q;
      wr_bank_d   = wr_bank_q;
      exp_band_d  = exp_band_q;
      frame_cnt_d = frame_cnt_q;
      tag_d       = tag_q;
      set_s       = 2'b00;
      we_s        = 1'b0;
      seq_err_d   = clear_flags ? 1'b0 : seq_err_q;
      ovf_cnt_d   = clear_flags ? {OVF_CNT_WIDTH{1'b0}} : ovf_cnt_q;
      if (din_valid) begin
         case (wr_state_q)
            WR_HUNT: begin
               if (band_number != ZERO_BAND) begin
                  wr_state_d = WR_HUNT;
               end else if (full_q[wr_bank_q] && !rel_s[wr_bank_q]) begin
                  wr_state_d = WR_DROP;
               end else begin
                  we_s       = 1'b1;
                  exp_band_d = ONE_BAND;
                  wr_state_d = WR_FILL;
               end
            end
            WR_FILL: begin
               if (band_number == exp_band_q) begin
                  we_s       = 1'b1;
                  exp_band_d = exp_band_q + ONE_BAND;
                  if (band_number == LAST_BAND) begin
                     set_s[wr_bank_q] = 1'b1;
                     tag_d[wr_bank_q] = frame_cnt_q;
                     frame_cnt_d      = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                     wr_bank_d        = ~wr_bank_q;
                     wr_state_d       = WR_HUNT;
                  end else begin
                     wr_state_d = WR_FILL;
                  end
               end else if (band_number == ZERO_BAND) begin
                  // a fresh band 0 mid-frame restarts the same bank
                  seq_err_d  = 1'b1;
                  we_s       = 1'b1;
                  exp_band_d = ONE_BAND;
                  wr_state_d = WR_FILL;
               end else begin
                  seq_err_d  = 1'b1;
                  wr_state_d = WR_HUNT;
               end
            end
            WR_DROP: begin
               if (band_number == LAST_BAND) begin
                  if (clear_flags) begin
                     ovf_cnt_d = OVF_ONE;
                  end else if (ovf_cnt_q == OVF_MAX) begin
                     ovf_cnt_d = OVF_MAX;
                  end else begin
                     ovf_cnt_d = ovf_cnt_q + OVF_ONE;
                  end
                  wr_state_d = WR_HUNT;
               end else begin
                  wr_state_d = WR_DROP;
               end
            end
            default: wr_state_d = WR_HUNT;
         endcase
      end else begin
         wr_state_d = wr_state_q;
      end
      full_d = (full_q & ~rel_s) | set_s;
   end

   // reader FSM; raddr pre-fetches the row needed at the next band boundary
   always_comb begin
      rd_state_d   = rd_state_q;
      rd_bank_d    = rd_bank_q;
      cur_band_d   = cur_band_q;
      cur_word_d   = cur_word_q;
      row_d        = row_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      dout_last_d  = dout_last_q;
      dout_frame_d = dout_frame_q;
      rel_s        = 2'b00;
      nxt_word_s   = cur_word_q + 2'd1;
      nxt_band_s   = cur_band_q + ONE_BAND;
      if (rd_state_q == RD_STREAM && cur_band_q != LAST_BAND) begin
         raddr_s = {rd_bank_q, nxt_band_s};
      end else if (rd_state_q == RD_STREAM) begin
         raddr_s = {~rd_bank_q, ZERO_BAND};
      end else begin
         raddr_s = {rd_bank_q, ZERO_BAND};
      end
      case (rd_state_q)
         RD_IDLE: begin
            if (full_q[rd_bank_q]) begin
               rd_state_d   = RD_STREAM;
               cur_band_d   = ZERO_BAND;
               cur_word_d   = W_R11;
               row_d        = rdata_s;
               dout_d       = rdata_s[0];
               dout_valid_d = 1'b1;
               dout_last_d  = 1'b0;
               dout_frame_d = tag_q[rd_bank_q];
            end else begin
               rd_state_d = RD_IDLE;
            end
         end
         RD_STREAM: begin
            if (dout_valid_q && dout_ready) begin
               if (cur_word_q != W_R12IM) begin
                  cur_word_d  = nxt_word_s;
                  dout_d      = row_q[nxt_word_s];
                  dout_last_d = (cur_band_q == LAST_BAND) && (nxt_word_s == W_R12IM);
               end else if (cur_band_q != LAST_BAND) begin
                  cur_band_d = nxt_band_s;
                  cur_word_d = W_R11;
                  row_d      = rdata_s;
                  dout_d     = rdata_s[0];
               end else begin
                  rel_s[rd_bank_q] = 1'b1;
                  rd_bank_d        = ~rd_bank_q;
                  if (full_q[~rd_bank_q]) begin
                     cur_band_d   = ZERO_BAND;
                     cur_word_d   = W_R11;
                     row_d        = rdata_s;
                     dout_d       = rdata_s[0];
                     dout_last_d  = 1'b0;
                     dout_frame_d = tag_q[~rd_bank_q];
                  end else begin
                     rd_state_d   = RD_IDLE;
                     dout_valid_d = 1'b0;
                     dout_last_d  = 1'b0;
                  end
               end
            end else begin
               rd_state_d = RD_STREAM;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // writer-side state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q  <= WR_HUNT;
         wr_bank_q   <= 1'b0;
         exp_band_q  <= ZERO_BAND;
         frame_cnt_q <= {FRAME_CNT_WIDTH{1'b0}};
         tag_q       <= '0;
         full_q      <= 2'b00;
         seq_err_q   <= 1'b0;
         ovf_cnt_q   <= {OVF_CNT_WIDTH{1'b0}};
      end else begin
         wr_state_q  <= wr_state_d;
         wr_bank_q   <= wr_bank_d;
         exp_band_q  <= exp_band_d;
         frame_cnt_q <= frame_cnt_d;
         tag_q       <= tag_d;
         full_q      <= full_d;
         seq_err_q   <= seq_err_d;
         ovf_cnt_q   <= ovf_cnt_d;
      end
   end

   // reader-side state and registered output word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q   <= RD_IDLE;
         rd_bank_q    <= 1'b0;
         cur_band_q   <= ZERO_BAND;
         cur_word_q   <= W_R11;
         row_q        <= '0;
         dout_q       <= {DIN_WIDTH{1'b0}};
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         dout_frame_q <= {FRAME_CNT_WIDTH{1'b0}};
      end else begin
         rd_state_q   <= rd_state_d;
         rd_bank_q    <= rd_bank_d;
         cur_band_q   <= cur_band_d;
         cur_word_q   <= cur_word_d;
         row_q        <= row_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         dout_frame_q <= dout_frame_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_band  = cur_band_q;
   assign dout_word  = cur_word_q;
   assign dout_last  = dout_last_q;
   assign dout_frame = dout_frame_q;
   assign seq_err    = seq_err_q;
   assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_band_corr_framer.sv
// Directed self-checking bench for band_corr_framer: ordering, latency,
// back-pressure, frame drop, sequence errors, reset and flag clearing.
module tb_band_corr_framer;

   localparam int DW = 32;
   localparam int BANDS = 4;
   localparam int FW = 16;
   localparam int OW = 8;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] r11 = '0, r22 = '0, r12_re = '0, r12_im = '0;
   logic          din_valid = 1'b0;
   logic [BW-1:0] band_number = '0;
   logic          clear_flags = 1'b0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic [BW-1:0] dout_band;
   logic [1:0]    dout_word;
   logic          dout_last;
   logic [FW-1:0] dout_frame;
   logic          seq_err;
   logic [OW-1:0] ovf_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_send_cyc = 0;

   logic [DW-1:0] cap_data [64];
   logic [BW-1:0] cap_band [64];
   logic [1:0]    cap_word [64];
   logic          cap_last [64];
   logic [FW-1:0] cap_frame [64];
   int            cap_cyc [64];
   int            cap_n;
   int            stall_bad;

   band_corr_framer dut (
      .clk(clk), .rst_n(rst_n), .r11(r11), .r22(r22), .r12_re(r12_re), .r12_im(r12_im),
      .din_valid(din_valid), .band_number(band_number), .clear_flags(clear_flags),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_band(dout_band),
      .dout_word(dout_word), .dout_last(dout_last), .dout_frame(dout_frame),
      .seq_err(seq_err), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] wval(input int w, input int b, input int k);
      return 32'(k * 256 + (w + 1) * 16 + b);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_tuple(input int b, input int k);
      r11 = wval(0, b, k); r22 = wval(1, b, k); r12_re = wval(2, b, k); r12_im = wval(3, b, k);
      band_number = BW'(b);
      din_valid = 1'b1;
      last_send_cyc = cyc;
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   task automatic send_frame(input int k);
      for (int b = 0; b < BANDS; b++) send_tuple(b, k);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din_valid = 1'b0; clear_flags = 1'b0; dout_ready = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   // records accepted words; also notes any change of output while stalled
   task automatic capture(input int n, input int budget, input bit rnd);
      int c;
      logic held;
      logic [DW+BW+2+1+FW-1:0] prev, now;
      cap_n = 0; stall_bad = 0; held = 1'b0; c = 0; prev = '0;
      while (cap_n < n && c < budget) begin
         dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         now = {dout, dout_band, dout_word, dout_last, dout_frame};
         if (held && (dout_valid !== 1'b1 || now !== prev)) stall_bad++;
         held = dout_valid && !dout_ready;
         prev = now;
         if (dout_valid === 1'b1 && dout_ready) begin
            cap_data[cap_n] = dout; cap_band[cap_n] = dout_band; cap_word[cap_n] = dout_word;
            cap_last[cap_n] = dout_last; cap_frame[cap_n] = dout_frame; cap_cyc[cap_n] = cyc;
            cap_n++;
         end
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [DW+1+BW+2+1+FW+1+OW-1:0] outs;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      outs = {dout, dout_valid, dout_band, dout_word, dout_last, dout_frame, seq_err, ovf_cnt};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      rst_n = 1'b1;
      idle(2);
      outs = {dout, dout_valid, dout_band, dout_word, dout_last, dout_frame, seq_err, ovf_cnt};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", outs); end
   endtask

   task automatic test_basic_frame();
      do_reset();
      dout_ready = 1'b1;
      send_frame(0);
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", dout_valid); end
      @(posedge clk); #1;
      capture(16, 40, 1'b0);
      checks++;
      if (cap_n != 16) begin errors++; $display("FAIL basic_count: got %0d expected 16", cap_n); end
      checks++;
      if (cap_cyc[0] != last_send_cyc + 2) begin
         errors++; $display("FAIL basic_latency: got %0d expected %0d", cap_cyc[0] - last_send_cyc, 2);
      end
      checks++;
      if (cap_data[0] !== 32'h10 || cap_data[1] !== 32'h20 || cap_data[4] !== 32'h11 || cap_data[15] !== 32'h43) begin
         errors++; $display("FAIL basic_literals: got %h %h %h %h expected 10 20 11 43",
                            cap_data[0], cap_data[1], cap_data[4], cap_data[15]);
      end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap_data[i] !== wval(i % 4, i / 4, 0) || cap_band[i] !== BW'(i / 4) || cap_word[i] !== 2'(i % 4)
             || cap_last[i] !== (i == 15) || cap_frame[i] !== 16'd0) begin
            errors++;
            $display("FAIL basic_word[%0d]: got %h b%0d w%0d l%b f%0d expected %h b%0d w%0d l%b f0",
                     i, cap_data[i], cap_band[i], cap_word[i], cap_last[i], cap_frame[i],
                     wval(i % 4, i / 4, 0), i / 4, i % 4, i == 15);
         end
      end
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid: got %b expected 0", dout_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_random_ready();
      do_reset();
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               send_frame(k);
               idle(40);
            end
         end
         capture(48, 2000, 1'b1);
      join
      checks++;
      if (cap_n != 48) begin errors++; $display("FAIL rand_count: got %0d expected 48", cap_n); end
      checks++;
      if (stall_bad != 0) begin errors++; $display("FAIL rand_stall_stable: got %0d changes expected 0", stall_bad); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap_data[i] !== wval(i % 4, (i % 16) / 4, i / 16) || cap_frame[i] !== FW'(i / 16)
             || cap_last[i] !== (i % 16 == 15)) begin
            errors++;
            $display("FAIL rand_word[%0d]: got %h f%0d l%b expected %h f%0d l%b", i, cap_data[i],
                     cap_frame[i], cap_last[i], wval(i % 4, (i % 16) / 4, i / 16), i / 16, i % 16 == 15);
         end
      end
      dout_ready = 1'b0;
   endtask

   task automatic test_overflow_back_to_back();
      do_reset();
      dout_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send_frame(k);
         idle(2);
      end
      @(negedge clk);
      checks++;
      if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_count: got %0d expected 1", ovf_cnt); end
      checks++;
      if (dout_valid !== 1'b1 || dout !== wval(0, 0, 0)) begin
         errors++; $display("FAIL ovf_stalled_head: got v%b %h expected v1 %h", dout_valid, dout, wval(0, 0, 0));
      end
      @(posedge clk); #1;
      capture(32, 200, 1'b0);
      checks++;
      if (cap_n != 32) begin errors++; $display("FAIL ovf_count_words: got %0d expected 32", cap_n); end
      checks++;
      if (cap_cyc[16] - cap_cyc[15] != 1) begin
         errors++; $display("FAIL ovf_back_to_back_gap: got %0d expected 1", cap_cyc[16] - cap_cyc[15]);
      end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap_data[i] !== wval(i % 4, (i % 16) / 4, i / 16) || cap_frame[i] !== FW'(i / 16)
             || cap_last[i] !== (i % 16 == 15)) begin
            errors++;
            $display("FAIL ovf_word[%0d]: got %h f%0d l%b expected %h f%0d l%b", i, cap_data[i],
                     cap_frame[i], cap_last[i], wval(i % 4, (i % 16) / 4, i / 16), i / 16, i % 16 == 15);
         end
      end
      idle(5);
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped_frame_out: got %b expected 0", dout_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_seq_err();
      do_reset();
      dout_ready = 1'b1;
      send_tuple(0, 9); send_tuple(1, 9); send_tuple(3, 9);
      idle(4);
      @(negedge clk);
      checks++;
      if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_set: got %b expected 1", seq_err); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL seq_no_output: got %b expected 0", dout_valid); end
      @(posedge clk); #1;
      send_frame(5);
      capture(16, 40, 1'b0);
      checks++;
      if (cap_n != 16 || cap_data[0] !== wval(0, 0, 5) || cap_data[15] !== wval(3, 3, 5) || cap_frame[15] !== 16'd0) begin
         errors++; $display("FAIL seq_clean_frame: got n%0d %h %h f%0d expected n16 %h %h f0",
                            cap_n, cap_data[0], cap_data[15], cap_frame[15], wval(0, 0, 5), wval(3, 3, 5));
      end
      send_tuple(0, 6); send_tuple(1, 6);
      send_frame(7);
      capture(16, 40, 1'b0);
      checks++;
      if (cap_n != 16 || cap_data[0] !== wval(0, 0, 7) || cap_data[5] !== wval(1, 1, 7) || cap_frame[0] !== 16'd1) begin
         errors++; $display("FAIL seq_restart_frame: got n%0d %h %h f%0d expected n16 %h %h f1",
                            cap_n, cap_data[0], cap_data[5], cap_frame[0], wval(0, 0, 7), wval(1, 1, 7));
      end
   endtask

   task automatic test_reset_midframe();
      logic [DW+1+BW+2+1+FW+1+OW-1:0] outs;
      do_reset();
      dout_ready = 1'b1;
      send_tuple(2, 1); send_tuple(3, 1);
      send_frame(2);
      capture(16, 40, 1'b0);
      checks++;
      if (cap_n != 16 || cap_data[0] !== wval(0, 0, 2) || cap_data[15] !== wval(3, 3, 2) || seq_err !== 1'b0) begin
         errors++; $display("FAIL mid_start_frame: got n%0d %h %h e%b expected n16 %h %h e0",
                            cap_n, cap_data[0], cap_data[15], seq_err, wval(0, 0, 2), wval(3, 3, 2));
      end
      send_frame(3);
      capture(5, 40, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      outs = {dout, dout_valid, dout_band, dout_word, dout_last, dout_frame, seq_err, ovf_cnt};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL mid_stream_reset: got %h expected 0", outs); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(6);
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_abandoned: got %b expected 0", dout_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_ovf_saturate_clear();
      do_reset();
      dout_ready = 1'b0;
      send_tuple(0, 1); send_tuple(1, 1); send_tuple(3, 1);
      send_frame(0);
      send_frame(1);
      for (int k = 0; k < 300; k++) send_frame(2);
      @(negedge clk);
      checks++;
      if (ovf_cnt !== 8'd255 || seq_err !== 1'b1) begin
         errors++; $display("FAIL sat_count: got %0d e%b expected 255 e1", ovf_cnt, seq_err);
      end
      @(posedge clk); #1;
      clear_flags = 1'b1;
      @(posedge clk); #1;
      clear_flags = 1'b0;
      @(negedge clk);
      checks++;
      if (ovf_cnt !== 8'd0 || seq_err !== 1'b0) begin
         errors++; $display("FAIL clear_flags: got %0d e%b expected 0 e0", ovf_cnt, seq_err);
      end
      @(posedge clk); #1;
      send_tuple(0, 3); send_tuple(1, 3); send_tuple(2, 3);
      clear_flags = 1'b1;
      send_tuple(3, 3);
      clear_flags = 1'b0;
      @(negedge clk);
      checks++;
      if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL clear_vs_event: got %0d expected 1", ovf_cnt); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_random_ready();
      test_overflow_back_to_back();
      test_seq_err();
      test_reset_midframe();
      test_ovf_saturate_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/band_corr_framer.md
Name: band_corr_framer

Overview:
- Sits directly downstream of the per-band correlator (no-linear-algebra DOA path).
- Captures the BANDS correlation tuples r11, r22, r12_re, r12_im produced for one accumulation frame into a ping-pong buffer.
- Streams each complete frame out over a ready/valid word stream toward the host/readout interface.
- Drops whole frames on back-pressure overflow and flags band-sequence errors.

Parameters:
- DIN_WIDTH, 32, width of each correlation word (matches correlator DOUT_WIDTH).
- BANDS, 4, bands per frame; power of two, >=2.
- FRAME_CNT_WIDTH, 16, width of the frame sequence counter.
- OVF_CNT_WIDTH, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r11, r22, r12_re, r12_im  in  DIN_WIDTH each  signed correlation tuple
- din_valid  in  1  tuple valid
- band_number  in  $clog2(BANDS)  band index of the tuple
- clear_flags  in  1  synchronous clear of seq_err and ovf_cnt
- dout  out  DIN_WIDTH  output word
- dout_valid  out  1  word valid
- dout_ready  in  1  downstream accepts the word
- dout_band  out  $clog2(BANDS)  band of the current word
- dout_word  out  2  word select: 0=r11, 1=r22, 2=r12_re, 3=r12_im
- dout_last  out  1  final word of the frame (band BANDS-1, word 3)
- dout_frame  out  FRAME_CNT_WIDTH  sequence number of the frame being streamed
- seq_err  out  1  sticky band-sequence error
- ovf_cnt  out  OVF_CNT_WIDTH  saturating count of dropped frames

Behaviour:
- Reset (async, rst_n=0): all outputs 0; both banks empty; writer in HUNT; reader in IDLE; bank pointers 0; frame counter 0.
- Storage: two banks, each holding BANDS x 4 words. Each bank has a full flag. Update rule: full_next = (full & ~release) | set.

Writer FSM, one tuple accepted per din_valid cycle:
- HUNT: waits for band_number==0.
  - Nonzero bands are discarded silently.
  - On band 0: if full[wr_bank] and that bank is not being released this cycle, go to DROP. Otherwise write slot 0 and go to FILL with expected band 1.
- FILL:
  - band==expected: write the slot. If band==BANDS-1, set full[wr_bank], tag the bank with the frame counter, increment the frame counter (wraps), toggle wr_bank, go to HUNT.
  - band!=expected and band==0: set seq_err; restart the fill in the same bank at slot 0 with this data.
  - band!=expected and band!=0: set seq_err; go to HUNT. The partial bank is not marked full.
- DROP: discards tuples. On band BANDS-1, ovf_cnt increments (saturating) and the FSM returns to HUNT. The frame counter does not advance for dropped frames.

Reader FSM:
- IDLE: when full[rd_bank], go to STREAM next cycle. dout_valid rises one cycle after the full flag sets, so the first word appears 2 cycles after the last-band din_valid.
- STREAM: emits words in band-major order (band 0 words 0..3, then band 1, ...), 4*BANDS words total.
  - dout, dout_band, dout_word, dout_last, dout_frame are registered.
  - While dout_valid=1 and dout_ready=0 they hold stable.
  - A word advances only on dout_valid & dout_ready.
  - Handshake on the last word: release rd_bank, toggle rd_bank. If the other bank is already full, continue streaming back-to-back with no idle cycle; otherwise go to IDLE.
- Simultaneous events:
  - Writer completing one bank while the reader releases the other: both take effect.
  - clear_flags together with a new seq_err/overflow event: the event wins (flag set / count = 1).
- Reset mid-frame: a partial frame and any in-flight stream are abandoned. The frame counter restarts at 0.

Decomposition:
- Shared package:
  - word-select constants W_R11=0, W_R22=1, W_R12RE=2, W_R12IM=3
  - writer state encodings HUNT/FILL/DROP
  - reader state encodings IDLE/STREAM
- Sub-module band_pingpong_ram: dual-bank simple dual-port RAM, 4*DIN_WIDTH wide, 2*BANDS deep, 1-cycle read. The reader pre-fetches so dout stays registered with zero bubble.

Test Plan:
- Frame bands 0..3 with r11=0x10+b, r22=0x20+b, r12_re=0x30+b, r12_im=0x40+b, dout_ready=1 -> 16 words 0x10,0x20,0x30,0x40,0x11,... First dout_valid 2 cycles after band 3; dout_last only on word 16 (0x43); dout_frame=0.
- Random dout_ready (50%) over 3 frames -> no word lost, duplicated or reordered; dout stable during stalls; dout_frame=0,1,2.
- dout_ready=0 while 3 frames arrive -> frames 0 and 1 buffered, third dropped; ovf_cnt=1. Releasing ready yields frame 0 then frame 1 back-to-back, with no idle cycle between word 16 and word 17.
- Band sequence 0,1,3 -> seq_err=1; no output. A following clean 0..3 frame streams normally with dout_frame=0. A sequence 0,1,0,1,2,3 streams the second partial run as a valid frame.
- Reset start mid-frame with bands 2,3 then 0..3 -> first two bands ignored, seq_err stays 0, one frame output. Asserting rst_n=0 during streaming word 5 -> all outputs 0 immediately.
- 300 dropped frames -> ovf_cnt saturates at 255. clear_flags -> ovf_cnt=0 and seq_err=0 next cycle.
